// File: rtl/cpu_memq.sv
// Memory request queue between the ALU stage and the dcache: circular buffer with write-address lookup.
// Latency 1 from push to head; dcache backpressure via cpu_dcache_ready; drops with a sticky overflow flag when full.
module cpu_memq #(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FULL_MARGIN = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       p3_mem_request,
  input  logic                       p3_mem_write,
  input  logic                       p3_mem_burst,
  input  logic [ADDR_W-1:0]          p3_mem_address,
  input  logic [DATA_W-1:0]          p3_mem_wdata,
  input  logic [DATA_W/8-1:0]        p3_mem_wstrb,
  input  logic                       flush,
  output logic                       cpu_dcache_request,
  input  logic                       cpu_dcache_ready,
  output logic                       cpu_dcache_write,
  output logic                       cpu_dcache_burst,
  output logic [ADDR_W-1:0]          cpu_dcache_address,
  output logic [DATA_W-1:0]          cpu_dcache_wdata,
  output logic [DATA_W/8-1:0]        cpu_dcache_wstrb,
  output logic                       mem_fifo_full,
  output logic [$clog2(DEPTH+1)-1:0] mem_fifo_count,
  output logic                       overflow_error,
  input  logic [ADDR_W-1:0]          lookup_address,
  output logic                       lookup_hit
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_AT = CNT_W'(DEPTH - FULL_MARGIN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [PTR_W-1:0]    r_head, r_tail;
  logic [CNT_W-1:0]    r_count;
  logic                r_full, r_overflow;
  logic                r_write [DEPTH];
  logic                r_burst [DEPTH];
  logic [ADDR_W-1:0]   r_addr  [DEPTH];
  logic [DATA_W-1:0]   r_wdata [DEPTH];
  logic [DATA_W/8-1:0] r_wstrb [DEPTH];

  logic             w_pop, w_push_ok, w_drop;
  logic [CNT_W-1:0] w_count_next;
  logic [PTR_W-1:0] w_head_next;
  logic             w_unused;

  // A pop alongside flush is irrelevant: flush empties the queue anyway.
  assign w_pop     = (r_count != '0) && cpu_dcache_ready && !flush;
  assign w_push_ok = p3_mem_request && (flush || (r_count != CNT_MAX) || w_pop);
  assign w_drop    = p3_mem_request && !w_push_ok;

  always_comb begin
    w_count_next = r_count;
    w_head_next  = r_head;
    if (flush) begin
      w_count_next = w_push_ok ? CNT_W'(1) : '0;
      w_head_next  = r_tail;
    end else begin
      w_count_next = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
      if (w_pop) w_head_next = r_head + PTR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_head  <= w_head_next;
      r_tail  <= r_tail + PTR_W'(w_push_ok);
      r_count <= w_count_next;
      r_full  <= (w_count_next >= FULL_AT);
      if (flush)       r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
      if (w_drop) $warning("cpu_memq: push dropped, queue at capacity, t=%0t", $time);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_write[r_tail] <= p3_mem_write;
      r_burst[r_tail] <= p3_mem_burst;
      r_addr[r_tail]  <= p3_mem_address;
      r_wdata[r_tail] <= p3_mem_wdata;
      r_wstrb[r_tail] <= p3_mem_wstrb;
    end
  end

  assign cpu_dcache_request = (r_count != '0);
  assign cpu_dcache_write   = r_write[r_head];
  assign cpu_dcache_burst   = r_burst[r_head];
  assign cpu_dcache_address = r_addr[r_head];
  assign cpu_dcache_wdata   = r_wdata[r_head];
  assign cpu_dcache_wstrb   = r_wstrb[r_head];
  assign mem_fifo_full      = r_full;
  assign mem_fifo_count     = r_count;
  assign overflow_error     = r_overflow;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] v_off;
      v_off = PTR_W'(i) - r_head;
      if ((CNT_W'(v_off) < r_count) && r_write[i] && (r_wstrb[i] != '0) &&
          (r_addr[i][ADDR_W-1:2] == lookup_address[ADDR_W-1:2]))
        lookup_hit = 1'b1;
    end
  end

  assign w_unused = &{1'b0, lookup_address[1:0]};
endmodule
